// File: rtl/block_packer.sv
// Byte-stream to 128-bit block packer feeding an ASCON-128a block processor.
// Packs tagged bytes MSB-first and sequences terminator and FINAL issues.
module block_packer #(
  parameter bit CHECK_KIND = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic [1:0]   s_kind,
  input  logic         s_last,
  input  logic         s_empty,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [2:0]   blk_type,
  input  logic         out_rdy,
  output logic [127:0] in_blk,
  output logic [7:0]   blk_len,
  output logic         in_rdy,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] in_blk_q, in_blk_d;
  logic [7:0]   blk_len_q, blk_len_d;
  logic         in_rdy_q, in_rdy_d;
  logic         err_q, err_d;
  logic         term_pend_q, term_pend_d;
  logic         busy_q, busy_d;
  logic         ready_en_q;

  logic         s_ready_c;
  logic         take;
  logic         kind_ok;
  logic         closing;
  logic [4:0]   cnt_inc;
  logic [6:0]   shamt;
  logic [127:0] blk_ins;

  // Input acceptance and the candidate block with the incoming byte merged in
  always_comb begin
    s_ready_c = ready_en_q && (state_q == FILL) && !term_pend_q && (blk_type != 3'd4);
    take      = s_valid && s_ready_c;
    kind_ok   = !CHECK_KIND || (!blk_type[2] && (s_kind == blk_type[1:0]));
    cnt_inc   = cnt_q + 5'd1;
    shamt     = {4'd15 - cnt_q[3:0], 3'b000};
    blk_ins   = ((cnt_q == 5'd0) ? 128'd0 : in_blk_q) | ({120'd0, s_data} << shamt);
    closing   = (cnt_inc == 5'd16) || s_last;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_blk_d    = in_blk_q;
    blk_len_d   = blk_len_q;
    in_rdy_d    = in_rdy_q;
    err_d       = err_q;
    term_pend_d = term_pend_q;
    case (state_q)
      FILL: begin
        if (term_pend_q) begin
          in_blk_d    = 128'd0;
          blk_len_d   = 8'd0;
          term_pend_d = 1'b0;
          in_rdy_d    = 1'b1;
          state_d     = ISSUE;
        end else if (blk_type == 3'd4) begin
          in_blk_d  = 128'd0;
          blk_len_d = 8'd0;
          cnt_d     = 5'd0;
          in_rdy_d  = 1'b1;
          state_d   = FIN;
        end else if (take) begin
          if (!kind_ok) begin
            err_d = 1'b1;
          end else if (s_last && s_empty) begin
            in_blk_d  = 128'd0;
            blk_len_d = 8'd0;
            in_rdy_d  = 1'b1;
            state_d   = ISSUE;
            err_d     = err_q || !s_kind[1];
          end else begin
            in_blk_d = blk_ins;
            cnt_d    = cnt_inc;
            if (closing) begin
              blk_len_d   = {cnt_inc, 3'b000};
              in_rdy_d    = 1'b1;
              state_d     = ISSUE;
              // key/nonce must be full blocks; a full data block ending its section needs a terminator
              err_d       = err_q || (!s_kind[1] && (cnt_inc != 5'd16));
              term_pend_d = s_kind[1] && s_last && (cnt_inc == 5'd16);
            end else begin
              state_d = FILL;
            end
          end
        end else begin
          state_d = FILL;
        end
      end
      ISSUE, FIN: begin
        if (in_rdy_q && out_rdy) begin
          in_rdy_d = 1'b0;
          state_d  = HOLD;
        end else begin
          in_rdy_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_rdy) begin
          cnt_d   = 5'd0;
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    busy_d = (state_d != FILL) || (cnt_d != 5'd0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= 5'd0;
      in_blk_q    <= 128'd0;
      blk_len_q   <= 8'd0;
      in_rdy_q    <= 1'b0;
      err_q       <= 1'b0;
      term_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_blk_q    <= in_blk_d;
      blk_len_q   <= blk_len_d;
      in_rdy_q    <= in_rdy_d;
      err_q       <= err_d;
      term_pend_q <= term_pend_d;
      busy_q      <= busy_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign s_ready = s_ready_c;
  assign in_blk  = in_blk_q;
  assign blk_len = blk_len_q;
  assign in_rdy  = in_rdy_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
